hazard_ctrl: RTL

//  Pipeline interlock controller for the 41-bit decode bundle path.
//  - Consumes decode source regs (hdu_src1/2) and EX-stage destination info.
//  - Sequences IF/ID holds, ID/EX bubbles and redirect flushes via a 3-state FSM.
//  - Sits between decode and the IF/ID, ID/EX pipeline registers; one per core.

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Load-use / redirect interlock controller: sequences IF/ID holds, ID/EX bubbles and flushes.
// Optional perf counters are built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int REG_W          = 3,
    parameter int LOAD_STALL_CYC = 1,
    parameter int FLUSH_CYC      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_busy,
    input  logic             id_valid,
    input  logic [REG_W-1:0] hdu_src1,
    input  logic [REG_W-1:0] hdu_src2,
    input  logic             src1_used,
    input  logic             src2_used,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_wr_en,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_redirect,
    output logic             hold_pc,
    output logic             hold_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             freeze_all,
    output logic [1:0]       hz_state,
    output logic [15:0]      stall_count,
    output logic [15:0]      flush_count
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_STALL = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [3:0] STALL_RELOAD = 4'(LOAD_STALL_CYC - 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYC - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;

    logic       w_luh;
    logic [1:0] w_next_state;
    logic [3:0] w_next_cnt;
    logic       w_stall;
    logic       w_flush;
    logic       w_freeze;

    assign w_luh = id_valid & ex_valid & ex_is_load & ex_wr_en &
                   ((src1_used & (hdu_src1 == ex_rd)) |
                    (src2_used & (hdu_src2 == ex_rd)));

    // A redirect wins in every state: the younger instruction is dead, so a
    // pending stall or flush countdown is simply replaced by a fresh flush.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        w_freeze     = 1'b0;
        if (mem_busy) begin
            w_freeze = 1'b1;
        end else if (ex_redirect) begin
            w_flush = 1'b1;
            if (FLUSH_CYC > 1) begin
                w_next_state = ST_FLUSH;
                w_next_cnt   = FLUSH_RELOAD;
            end else begin
                w_next_state = ST_RUN;
                w_next_cnt   = 4'd0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_luh) begin
                        w_stall = 1'b1;
                        if (LOAD_STALL_CYC > 1) begin
                            w_next_state = ST_STALL;
                            w_next_cnt   = STALL_RELOAD;
                        end
                    end
                end
                ST_STALL: begin
                    w_stall    = 1'b1;
                    w_next_cnt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    w_flush    = 1'b1;
                    w_next_cnt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Controls are gated by reset so they drop the instant rst falls.
    assign hold_pc     = rst & w_stall;
    assign hold_ifid   = rst & w_stall;
    assign bubble_idex = rst & w_stall;
    assign flush_ifid  = rst & w_flush;
    assign flush_idex  = rst & w_flush;
    assign freeze_all  = rst & w_freeze;
    assign hz_state    = r_state;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    // Only a fresh redirect counts; flush cycles of a countdown do not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else begin
            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (w_flush && ex_redirect && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`else
    assign stall_count = 16'd0;
    assign flush_count = 16'd0;
`endif

endmodule
